// File: rtl/mvu_pkg.sv
// Shared types and constants for the multi-channel MVU bit-plane transposer.
package mvu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } tp_state_e;

    localparam int unsigned TP_MAX_PREC = 16;
    localparam int unsigned TP_NBLK_W   = 16;

endpackage

// File: rtl/mvu_tp_bank.sv
// One transposer buffer: NUM_WORDS elements of MAX_PREC bits, written one element
// at a time and read back one bit-plane at a time.
module mvu_tp_bank #(
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned MAX_PREC  = 16,
    parameter int unsigned IDX_W     = 6,
    parameter int unsigned PL_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IDX_W-1:0]     widx,
    input  logic [MAX_PREC-1:0]  wdata,
    input  logic [PL_W-1:0]      plane,
    output logic [NUM_WORDS-1:0] rplane
);

    logic [MAX_PREC-1:0] mem_q [NUM_WORDS];

    // Element storage; one element written per accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    // Plane read: bit i of the plane is bit 'plane' of element i.
    always_comb begin
        rplane = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            rplane[i] = mem_q[i][plane];
        end
    end

endmodule

// File: rtl/mvu_data_transposer_mc.sv
// Multi-channel bit-plane transposer: collects NUM_WORDS elements per block into
// one of two banks and drains each full bank as prec bit-plane words, MSB first,
// to the selected MVU data RAM.
// Optional feature: define MVU_TP_STATS_EN to add the stall_cnt output.
module mvu_data_transposer_mc
    import mvu_pkg::*;
#(
    parameter int unsigned NCHAN     = 8,
    parameter int unsigned NUM_WORDS = 64,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned MAX_PREC  = TP_MAX_PREC,
    parameter int unsigned CH_W      = (NCHAN > 1) ? $clog2(NCHAN) : 1,
    parameter int unsigned PREC_W    = $clog2(MAX_PREC) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [PREC_W-1:0]    cfg_prec,
    input  logic [ADDR_W-1:0]    cfg_baddr,
    input  logic [CH_W-1:0]      cfg_chan,
    input  logic [TP_NBLK_W-1:0] cfg_nblk,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_word,
    output logic [NCHAN-1:0]     wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [NUM_WORDS-1:0] wr_word,
    output logic                 busy,
    output logic                 done,
`ifdef MVU_TP_STATS_EN
    output logic [31:0]          stall_cnt,
`endif
    output logic                 err
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned PL_W  = (MAX_PREC > 1) ? $clog2(MAX_PREC) : 1;

    tp_state_e               state_q, state_d;
    logic [PREC_W-1:0]       prec_q, prec_d;
    logic [CH_W-1:0]         chan_q, chan_d;
    logic [TP_NBLK_W-1:0]    nblk_q, nblk_d;
    logic [TP_NBLK_W-1:0]    blk_in_q, blk_in_d;
    logic [TP_NBLK_W-1:0]    blk_out_q, blk_out_d;
    logic [IDX_W-1:0]        e_q, e_d;
    logic                    fill_bank_q, fill_bank_d;
    logic                    drain_bank_q, drain_bank_d;
    logic [1:0]              full_q, full_d;
    logic [PL_W-1:0]         plane_q, plane_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    last_q, last_d;
    logic [NCHAN-1:0]        wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [NUM_WORDS-1:0]    wr_word_q, wr_word_d;
    logic                    err_q, err_d;
`ifdef MVU_TP_STATS_EN
    logic [31:0]             stall_q, stall_d;
`endif

    logic                    start_legal;
    logic                    accept;
    logic                    drain_go;
    logic [1:0]              bank_we;
    logic [NUM_WORDS-1:0]    plane_rd [2];

    assign start_legal = (cfg_prec != '0) && (cfg_prec <= PREC_W'(MAX_PREC)) &&
                         (cfg_nblk != '0);
    assign accept      = in_valid & in_ready;
    assign drain_go    = (state_q == StRun) && full_q[drain_bank_q];

    // Element bits above MAX_PREC never reach a bank.
    if (XLEN > MAX_PREC) begin : g_unused_upper
        logic unused_upper;
        assign unused_upper = ^in_word[XLEN-1:MAX_PREC];
    end

    mvu_tp_bank #(
        .NUM_WORDS (NUM_WORDS),
        .MAX_PREC  (MAX_PREC),
        .IDX_W     (IDX_W),
        .PL_W      (PL_W)
    ) u_bank0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bank_we[0]),
        .widx   (e_q),
        .wdata  (in_word[MAX_PREC-1:0]),
        .plane  (plane_q),
        .rplane (plane_rd[0])
    );

    mvu_tp_bank #(
        .NUM_WORDS (NUM_WORDS),
        .MAX_PREC  (MAX_PREC),
        .IDX_W     (IDX_W),
        .PL_W      (PL_W)
    ) u_bank1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (bank_we[1]),
        .widx   (e_q),
        .wdata  (in_word[MAX_PREC-1:0]),
        .plane  (plane_q),
        .rplane (plane_rd[1])
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: DONE follows the cycle in which the final plane is written.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_start && start_legal) state_d = StRun;
            StRun:   if (last_q) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM-derived outputs and registered write port.
    always_comb begin
        in_ready = (state_q == StRun) && !full_q[fill_bank_q] && (blk_in_q < nblk_q);
        busy     = (state_q == StRun);
        done     = (state_q == StDone);
        wr_en    = wr_en_q;
        wr_addr  = wr_addr_q;
        wr_word  = wr_word_q;
        err      = err_q;
`ifdef MVU_TP_STATS_EN
        stall_cnt = stall_q;
`endif
    end

    // Datapath next state: config capture, fill pointer, drain pointer, address.
    always_comb begin
        prec_d       = prec_q;
        chan_d       = chan_q;
        nblk_d       = nblk_q;
        blk_in_d     = blk_in_q;
        blk_out_d    = blk_out_q;
        e_d          = e_q;
        fill_bank_d  = fill_bank_q;
        drain_bank_d = drain_bank_q;
        full_d       = full_q;
        plane_d      = plane_q;
        addr_d       = addr_q;
        last_d       = last_q;
        wr_en_d      = '0;
        wr_addr_d    = wr_addr_q;
        wr_word_d    = wr_word_q;
        err_d        = err_q;
        bank_we      = '0;
`ifdef MVU_TP_STATS_EN
        stall_d      = stall_q;
`endif

        if (cfg_start) begin
            if (state_q != StIdle || !start_legal) begin
                err_d = 1'b1;
            end else begin
                prec_d       = cfg_prec;
                chan_d       = cfg_chan;
                nblk_d       = cfg_nblk;
                blk_in_d     = '0;
                blk_out_d    = '0;
                e_d          = '0;
                fill_bank_d  = 1'b0;
                drain_bank_d = 1'b0;
                full_d       = '0;
                plane_d      = PL_W'(cfg_prec - PREC_W'(1));
                addr_d       = cfg_baddr;
                last_d       = 1'b0;
                err_d        = 1'b0;
`ifdef MVU_TP_STATS_EN
                stall_d      = '0;
`endif
            end
        end

        if (drain_go) begin
            wr_en_d   = NCHAN'(1) << chan_q;
            wr_addr_d = addr_q;
            wr_word_d = plane_rd[drain_bank_q];
            addr_d    = addr_q + ADDR_W'(1);
            if (plane_q == '0) begin
                full_d[drain_bank_q] = 1'b0;
                drain_bank_d         = ~drain_bank_q;
                plane_d              = PL_W'(prec_q - PREC_W'(1));
                blk_out_d            = blk_out_q + TP_NBLK_W'(1);
                if (blk_out_q == nblk_q - TP_NBLK_W'(1)) begin
                    last_d = 1'b1;
                end
            end else begin
                plane_d = plane_q - PL_W'(1);
            end
        end

        // Fill updates come after drain so a completing fill wins on a shared bank.
        if (accept) begin
            bank_we[fill_bank_q] = 1'b1;
            if (e_q == IDX_W'(NUM_WORDS - 1)) begin
                e_d                 = '0;
                full_d[fill_bank_q] = 1'b1;
                fill_bank_d         = ~fill_bank_q;
                blk_in_d            = blk_in_q + TP_NBLK_W'(1);
            end else begin
                e_d = e_q + IDX_W'(1);
            end
        end

        if (state_q == StDone) begin
            last_d = 1'b0;
        end

`ifdef MVU_TP_STATS_EN
        if ((state_q == StRun) && in_valid && !in_ready && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
`endif
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prec_q       <= '0;
            chan_q       <= '0;
            nblk_q       <= '0;
            blk_in_q     <= '0;
            blk_out_q    <= '0;
            e_q          <= '0;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            full_q       <= '0;
            plane_q      <= '0;
            addr_q       <= '0;
            last_q       <= 1'b0;
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_word_q    <= '0;
            err_q        <= 1'b0;
`ifdef MVU_TP_STATS_EN
            stall_q      <= '0;
`endif
        end else begin
            prec_q       <= prec_d;
            chan_q       <= chan_d;
            nblk_q       <= nblk_d;
            blk_in_q     <= blk_in_d;
            blk_out_q    <= blk_out_d;
            e_q          <= e_d;
            fill_bank_q  <= fill_bank_d;
            drain_bank_q <= drain_bank_d;
            full_q       <= full_d;
            plane_q      <= plane_d;
            addr_q       <= addr_d;
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_word_q    <= wr_word_d;
            err_q        <= err_d;
`ifdef MVU_TP_STATS_EN
            stall_q      <= stall_d;
`endif
        end
    end

endmodule

// File: tb/tb_mvu_data_transposer_mc.sv
// Bench for mvu_data_transposer_mc: a default instance (64-element blocks) and a
// small instance (8-element blocks) to force back-pressure.
module tb_mvu_data_transposer_mc;

    typedef struct packed {
        logic [7:0]  en;
        logic [14:0] addr;
        logic [63:0] word;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_start, s_cfg_start;
    logic [4:0]  cfg_prec;
    logic [14:0] cfg_baddr;
    logic [2:0]  cfg_chan;
    logic [15:0] cfg_nblk;
    logic        in_valid, s_in_valid;
    logic [31:0] in_word, s_in_word;
    logic        in_ready, s_in_ready;
    logic [7:0]  wr_en, s_wr_en;
    logic [14:0] wr_addr, s_wr_addr;
    logic [63:0] wr_word;
    logic [7:0]  s_wr_word;
    logic        busy, s_busy, done, s_done, err, s_err;
`ifdef MVU_TP_STATS_EN
    logic [31:0] stall_cnt, s_stall_cnt;
`endif

    int          vec_cnt = 0;
    int          miss_cnt = 0;
    int          cyc = 0;
    int          lw = 0, s_lw = 0;
    wr_t         q[$], sq[$];
    logic [31:0] blk [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mvu_data_transposer_mc u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_prec  (cfg_prec),
        .cfg_baddr (cfg_baddr),
        .cfg_chan  (cfg_chan),
        .cfg_nblk  (cfg_nblk),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_word   (wr_word),
        .busy      (busy),
        .done      (done),
`ifdef MVU_TP_STATS_EN
        .stall_cnt (stall_cnt),
`endif
        .err       (err)
    );

    mvu_data_transposer_mc #(.NUM_WORDS(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (s_cfg_start),
        .cfg_prec  (cfg_prec),
        .cfg_baddr (cfg_baddr),
        .cfg_chan  (cfg_chan),
        .cfg_nblk  (cfg_nblk),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_word   (s_in_word),
        .wr_en     (s_wr_en),
        .wr_addr   (s_wr_addr),
        .wr_word   (s_wr_word),
        .busy      (s_busy),
        .done      (s_done),
`ifdef MVU_TP_STATS_EN
        .stall_cnt (s_stall_cnt),
`endif
        .err       (s_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop on every write cycle of either instance.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && wr_en !== 8'h00) begin
            lw = cyc;
            if (q.size() == 0) chk("main_extra_write", {56'h0, wr_en}, 64'h0);
            else begin
                e = q.pop_front();
                chk("main_wr_en", {56'h0, wr_en}, {56'h0, e.en});
                chk("main_wr_addr", {49'h0, wr_addr}, {49'h0, e.addr});
                chk("main_wr_word", wr_word, e.word);
            end
        end
        if (rst_n && s_wr_en !== 8'h00) begin
            s_lw = cyc;
            if (sq.size() == 0) chk("small_extra_write", {56'h0, s_wr_en}, 64'h0);
            else begin
                e = sq.pop_front();
                chk("small_wr_en", {56'h0, s_wr_en}, {56'h0, e.en});
                chk("small_wr_addr", {49'h0, s_wr_addr}, {49'h0, e.addr});
                chk("small_wr_word", {56'h0, s_wr_word}, e.word);
            end
        end
    end

    // Expected planes for block k: plane b at baddr + k*prec + (prec-1-b).
    task automatic push_block(input bit sel, input int prec, input int chan,
                              input logic [14:0] baddr, input int k);
        int   nw = sel ? 8 : 64;
        wr_t  e;
        for (int b = prec - 1; b >= 0; b--) begin
            e.word = '0;
            for (int i = 0; i < nw; i++) e.word[i] = blk[i][b];
            e.en   = 8'(1 << chan);
            e.addr = baddr + 15'(k * prec + (prec - 1 - b));
            if (sel) sq.push_back(e);
            else q.push_back(e);
        end
    endtask

    task automatic start_run(input bit sel, input int prec, input int chan,
                             input logic [14:0] baddr, input int nblk);
        cfg_prec  = 5'(prec);
        cfg_chan  = 3'(chan);
        cfg_baddr = baddr;
        cfg_nblk  = 16'(nblk);
        if (sel) s_cfg_start = 1'b1;
        else cfg_start = 1'b1;
        @(negedge clk);
        cfg_start   = 1'b0;
        s_cfg_start = 1'b0;
    endtask

    // Offer one beat (entered at a negedge); returns the cycles spent waiting.
    task automatic send(input bit sel, input logic [31:0] v, output int waits);
        int t = 0;
        if (sel) begin s_in_valid = 1'b1; s_in_word = v; end
        else begin in_valid = 1'b1; in_word = v; end
        while (!(sel ? s_in_ready : in_ready) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) chk("send_timeout", 64'(t), 64'h0);
        @(negedge clk);
        waits = t;
    endtask

    task automatic send_block(input bit sel, output int waits);
        int w;
        waits = 0;
        for (int i = 0; i < (sel ? 8 : 64); i++) begin
            send(sel, blk[i], w);
            waits += w;
        end
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int t = 0;
        while (!(sel ? s_done : done) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_done"}, {63'h0, sel ? s_done : done}, 64'h1);
        chk({tag, "_done_gap"}, 64'(cyc - (sel ? s_lw : lw)), 64'h1);
        chk({tag, "_busy_at_done"}, {63'h0, sel ? s_busy : busy}, 64'h0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0;
        cfg_start = 1'b0; s_cfg_start = 1'b0;
        cfg_prec = '0; cfg_baddr = '0; cfg_chan = '0; cfg_nblk = '0;
        in_valid = 1'b0; s_in_valid = 1'b0; in_word = '0; s_in_word = '0;
        repeat (3) @(negedge clk);
        chk("rst_wr_en", {56'h0, wr_en}, 64'h0);
        chk("rst_wr_addr", {49'h0, wr_addr}, 64'h0);
        chk("rst_wr_word", wr_word, 64'h0);
        chk("rst_flags", {59'h0, busy, done, err, in_ready, s_err}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {62'h0, in_ready, busy}, 64'h0);

        // 1: prec 2, elements i%4 -> 0xCCCC.. then 0xAAAA..
        start_run(0, 2, 3, 15'h10, 1);
        q.push_back('{en: 8'h08, addr: 15'h10, word: 64'hCCCC_CCCC_CCCC_CCCC});
        q.push_back('{en: 8'h08, addr: 15'h11, word: 64'hAAAA_AAAA_AAAA_AAAA});
        for (int i = 0; i < 64; i++) blk[i] = 32'(i % 4);
        send_block(0, w);
        in_valid = 1'b0;
        chk("t1_ready_after_final", {63'h0, in_ready}, 64'h0);
        wait_done(0, "t1");

        // 2: prec 8, three blocks with valid held; never back-pressured
        start_run(0, 8, 1, 15'h100, 3);
        begin
            int tot = 0;
            for (int k = 0; k < 3; k++) begin
                for (int i = 0; i < 64; i++) blk[i] = $urandom;
                push_block(0, 8, 1, 15'h100, k);
                send_block(0, w);
                tot += w;
                if (k == 1) chk("t2_busy", {63'h0, busy}, 64'h1);
            end
            in_valid = 1'b0;
            chk("t2_waits", 64'(tot), 64'h0);
        end
        wait_done(0, "t2");

        // 3: 8-element blocks, prec 16 -> drain slower than fill
        start_run(1, 16, 5, 15'h200, 4);
        begin
            int tot = 0;
            for (int k = 0; k < 4; k++) begin
                for (int i = 0; i < 8; i++) blk[i] = $urandom;
                push_block(1, 16, 5, 15'h200, k);
                send_block(1, w);
                tot += w;
            end
            s_in_valid = 1'b0;
            chk("t3_backpressure", {63'h0, tot > 0}, 64'h1);
        end
`ifdef MVU_TP_STATS_EN
        chk("t3_stall_cnt_nonzero", {63'h0, s_stall_cnt > 0}, 64'h1);
`endif
        wait_done(1, "t3");

        // 4: illegal start, then legal start clears err; start during run sets it
        start_run(0, 0, 0, 15'h40, 1);
        chk("t4_err", {63'h0, err}, 64'h1);
        chk("t4_busy", {63'h0, busy}, 64'h0);
        repeat (3) @(negedge clk);
        chk("t4_no_wr", {56'h0, wr_en}, 64'h0);
        start_run(0, 1, 0, 15'h40, 1);
        chk("t4_err_cleared", {63'h0, err}, 64'h1 ^ 64'h1);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        chk("t4_err_in_run", {63'h0, err}, 64'h1);
        for (int i = 0; i < 64; i++) blk[i] = $urandom;
        push_block(0, 1, 0, 15'h40, 0);
        send_block(0, w);
        in_valid = 1'b0;
        wait_done(0, "t4");
        chk("t4_err_sticky", {63'h0, err}, 64'h1);

        // 5: reset during drain
        start_run(0, 16, 2, 15'h300, 1);
        for (int i = 0; i < 64; i++) blk[i] = $urandom;
        push_block(0, 16, 2, 15'h300, 0);
        send_block(0, w);
        in_valid = 1'b0;
        begin
            int t = 0;
            while (wr_en === 8'h00 && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("t5_drain_started", {63'h0, wr_en !== 8'h00}, 64'h1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_en", {56'h0, wr_en}, 64'h0);
        chk("t5_rst_flags", {61'h0, busy, in_ready, err}, 64'h0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 6: address wraps from the top of the RAM
        start_run(0, 2, 7, 15'h7FFF, 1);
        for (int i = 0; i < 64; i++) blk[i] = $urandom;
        push_block(0, 2, 7, 15'h7FFF, 0);
        send_block(0, w);
        in_valid = 1'b0;
        wait_done(0, "t6");
        chk("t6_last_addr", {49'h0, wr_addr}, 64'h0);

        chk("q_empty", 64'(q.size()), 64'h0);
        chk("sq_empty", 64'(sq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
